// File: rtl/replay_stats_pkg.sv
// Shared constants and types for the replay statistics engine.
package replay_stats_pkg;

    // ctrl word bit positions
    localparam int unsigned CTRL_EN   = 0;
    localparam int unsigned CTRL_CLR  = 1;
    localparam int unsigned CTRL_SNAP = 2;

    // ro register word indices
    localparam int unsigned RO_PKT_LO  = 0;
    localparam int unsigned RO_PKT_HI  = 1;
    localparam int unsigned RO_BYTE_LO = 2;
    localparam int unsigned RO_BYTE_HI = 3;
    localparam int unsigned RO_STATUS  = 4;
    localparam int unsigned RO_MAX_LEN = 5;
    localparam int unsigned RO_WORDS   = 6;

    // status word bit positions
    localparam int unsigned ST_SNAP_VALID = 0;
    localparam int unsigned ST_OVF        = 1;
    localparam int unsigned ST_SEQ_LSB    = 16;
    localparam int unsigned SEQ_WIDTH     = 16;

    // packet length accumulator width (saturating)
    localparam int unsigned LEN_WIDTH = 16;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_IN_PKT = 2'd1,
        S_DROP   = 2'd2
    } state_t;

endpackage

// File: rtl/replay_stats_regs_keep_popcount.sv
// Combinational population count of a tkeep vector.
module keep_popcount #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]         keep,
    output logic [$clog2(WIDTH):0]   count
);

    // Sum of set keep bits
    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            count = count + ($clog2(WIDTH)+1)'(keep[i]);
        end
    end

endmodule

// File: rtl/replay_stats_regs.sv
// Passive AXI-Stream statistics engine with atomic snapshot register bank.
module replay_stats_regs
    import replay_stats_pkg::*;
#(
    parameter int unsigned C_S_AXIS_DATA_WIDTH = 256,
    parameter int unsigned C_S_AXI_DATA_WIDTH  = 32,
    parameter int unsigned CNT_WIDTH           = 64
) (
    input  logic                                axi_aclk,
    input  logic                                axi_areset,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
    input  logic                                s_axis_tvalid,
    input  logic                                s_axis_tready,
    input  logic                                s_axis_tlast,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]       ctrl,
    output logic [6*C_S_AXI_DATA_WIDTH-1:0]     ro_regs
);

    localparam int unsigned KW = C_S_AXIS_DATA_WIDTH / 8;
    localparam int unsigned BW = $clog2(KW) + 1;
    localparam int unsigned DW = C_S_AXI_DATA_WIDTH;

    logic [BW-1:0]        beat_bytes;
    logic                 beat;
    logic [1:0]           ctrl_d;
    logic                 clr_edge;
    logic                 snap_edge;
    logic                 enable;
    logic                 ctrl_unused;

    state_t               state;
    state_t               state_next;
    logic [LEN_WIDTH-1:0] len;
    logic [LEN_WIDTH-1:0] len_next;
    logic [LEN_WIDTH-1:0] len_acc;
    logic [LEN_WIDTH-1:0] len_commit;
    logic [LEN_WIDTH:0]   len_wide;
    logic                 commit;

    logic [CNT_WIDTH-1:0] pkt_cnt;
    logic [CNT_WIDTH-1:0] byte_cnt;
    logic [CNT_WIDTH:0]   byte_sum;
    logic [LEN_WIDTH-1:0] max_len;
    logic                 ovf;

    logic [CNT_WIDTH-1:0] sh_pkt;
    logic [CNT_WIDTH-1:0] sh_byte;
    logic [LEN_WIDTH-1:0] sh_max;
    logic                 sh_ovf;
    logic [SEQ_WIDTH-1:0] seq;
    logic                 snap_valid;
    logic [DW-1:0]        status_word;

    keep_popcount #(.WIDTH(KW)) u_popcount (
        .keep  (s_axis_tkeep),
        .count (beat_bytes)
    );

    assign beat        = s_axis_tvalid & s_axis_tready;
    assign enable      = ctrl[CTRL_EN];
    assign clr_edge    = ctrl[CTRL_CLR]  & ~ctrl_d[0];
    assign snap_edge   = ctrl[CTRL_SNAP] & ~ctrl_d[1];
    assign ctrl_unused = &{1'b0, ctrl[DW-1:3]};

    // Saturating length accumulate and widened byte commit sum
    assign len_wide = {1'b0, len} + (LEN_WIDTH+1)'(beat_bytes);
    assign len_acc  = len_wide[LEN_WIDTH] ? '1 : len_wide[LEN_WIDTH-1:0];
    assign byte_sum = {1'b0, byte_cnt} + (CNT_WIDTH+1)'(len_commit);

    // Edge-detect history for clear and snapshot bits
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) ctrl_d <= '1;
        else            ctrl_d <= ctrl[CTRL_SNAP:CTRL_CLR];
    end

    // Packet FSM state and length register
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state <= S_IDLE;
            len   <= '0;
        end else begin
            state <= state_next;
            len   <= len_next;
        end
    end

    // Packet FSM next state, length update and commit decision
    always_comb begin
        state_next = state;
        len_next   = len;
        len_commit = len_acc;
        commit     = 1'b0;
        case (state)
            S_IDLE: begin
                if (beat) begin
                    if (s_axis_tlast) begin
                        commit     = enable;
                        len_commit = LEN_WIDTH'(beat_bytes);
                    end else if (enable) begin
                        state_next = S_IN_PKT;
                        len_next   = LEN_WIDTH'(beat_bytes);
                    end else begin
                        state_next = S_DROP;
                        len_next   = '0;
                    end
                end
            end
            S_IN_PKT: begin
                if (beat) begin
                    if (s_axis_tlast) begin
                        commit     = 1'b1;
                        state_next = S_IDLE;
                        len_next   = '0;
                    end else begin
                        len_next   = len_acc;
                    end
                end
            end
            S_DROP: begin
                if (beat && s_axis_tlast) state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
                len_next   = '0;
            end
        endcase
    end

    // Live counters; snapshot samples pre-update values, clear overrides commit
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            pkt_cnt    <= '0;
            byte_cnt   <= '0;
            max_len    <= '0;
            ovf        <= 1'b0;
            sh_pkt     <= '0;
            sh_byte    <= '0;
            sh_max     <= '0;
            sh_ovf     <= 1'b0;
            seq        <= '0;
            snap_valid <= 1'b0;
        end else begin
            if (snap_edge) begin
                sh_pkt     <= pkt_cnt;
                sh_byte    <= byte_cnt;
                sh_max     <= max_len;
                sh_ovf     <= ovf;
                seq        <= seq + 1'b1;
                snap_valid <= 1'b1;
            end
            if (clr_edge) begin
                pkt_cnt  <= '0;
                byte_cnt <= '0;
                max_len  <= '0;
                ovf      <= 1'b0;
            end else if (commit) begin
                pkt_cnt  <= pkt_cnt + 1'b1;
                byte_cnt <= byte_sum[CNT_WIDTH-1:0];
                if (byte_sum[CNT_WIDTH]) ovf <= 1'b1;
                if (len_commit > max_len) max_len <= len_commit;
            end
        end
    end

    // Register bank assembly from shadow flops
    always_comb begin
        status_word                           = '0;
        status_word[ST_SNAP_VALID]            = snap_valid;
        status_word[ST_OVF]                   = sh_ovf;
        status_word[ST_SEQ_LSB +: SEQ_WIDTH]  = seq;

        ro_regs                               = '0;
        ro_regs[RO_PKT_LO*DW  +: DW]          = sh_pkt[DW-1:0];
        ro_regs[RO_PKT_HI*DW  +: DW]          = sh_pkt[CNT_WIDTH-1:DW];
        ro_regs[RO_BYTE_LO*DW +: DW]          = sh_byte[DW-1:0];
        ro_regs[RO_BYTE_HI*DW +: DW]          = sh_byte[CNT_WIDTH-1:DW];
        ro_regs[RO_STATUS*DW  +: DW]          = status_word;
        ro_regs[RO_MAX_LEN*DW +: DW]          = DW'(sh_max);
    end

endmodule
